// File: rtl/concat_cmd_scheduler.sv
// Splits a class-token CONCAT job into DDR copy commands: one class-token pixel
// per channel slice followed by feature-map bursts, with an outstanding-command cap.
module concat_cmd_scheduler #(
  parameter int ADDR_W          = 32,
  parameter int PIXEL_BYTES     = 32,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16,
  localparam int LEN_W          = $clog2(MAX_BURST) + 1,
  localparam int OST_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_pixels,
  input  logic [CNT_W-1:0]  cfg_ch_slices,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_in_surface_stride,
  input  logic [ADDR_W-1:0] cfg_cls_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [ADDR_W-1:0] cfg_out_surface_stride,
  output logic              busy,
  output logic              done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_src_addr,
  output logic [ADDR_W-1:0] cmd_dst_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_last,
  input  logic              cpl_valid
);

  typedef enum logic [2:0] {IDLE, CLS, FEAT, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] PB = ADDR_W'(PIXEL_BYTES);
  localparam logic [CNT_W-1:0]  MB = CNT_W'(MAX_BURST);

  state_t            state;
  logic [CNT_W-1:0]  pixels_q, slices_q, slice, pix;
  logic [ADDR_W-1:0] in_stride_q, out_stride_q;
  logic [ADDR_W-1:0] in_slice, cls_src, out_slice;
  logic              cmd_pend;
  logic [OST_W-1:0]  ost;

  function automatic logic [LEN_W-1:0] burst_len(input logic [CNT_W-1:0] remaining);
    if (remaining > MB) return LEN_W'(MAX_BURST);
    return LEN_W'(remaining);
  endfunction

  logic              hs, dec, ost_full;
  logic [CNT_W-1:0]  pix_nxt, rem_nxt, slice_nxt;
  logic              feat_more, last_slice, last_slice_nxt, adv_slice;
  logic [ADDR_W-1:0] feat_step;

  // A completion in the same cycle frees a slot, so the cap is bypassed combinationally.
  assign ost_full  = (ost == OST_W'(MAX_OUTSTANDING));
  assign cmd_valid = cmd_pend && (!ost_full || cpl_valid);
  assign hs        = cmd_valid && cmd_ready;
  assign dec       = cpl_valid && (ost != '0);

  assign pix_nxt        = pix + CNT_W'(cmd_len);
  assign rem_nxt        = pixels_q - pix_nxt;
  assign feat_more      = (pix_nxt != pixels_q);
  assign slice_nxt      = slice + CNT_W'(1);
  assign last_slice     = (slice == slices_q - CNT_W'(1));
  assign last_slice_nxt = (slice_nxt == slices_q - CNT_W'(1));
  assign feat_step      = ADDR_W'(cmd_len) * PB;
  assign adv_slice      = hs && !cmd_last &&
                          (((state == CLS) && (pixels_q == '0)) ||
                           ((state == FEAT) && !feat_more));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      cmd_pend     <= 1'b0;
      cmd_src_addr <= '0;
      cmd_dst_addr <= '0;
      cmd_len      <= '0;
      cmd_last     <= 1'b0;
      ost          <= '0;
      pixels_q     <= '0;
      slices_q     <= '0;
      slice        <= '0;
      pix          <= '0;
      in_stride_q  <= '0;
      out_stride_q <= '0;
      in_slice     <= '0;
      cls_src      <= '0;
      out_slice    <= '0;
    end else begin
      done <= 1'b0;
      case ({hs, dec})
        2'b10:   ost <= ost + OST_W'(1);
        2'b01:   ost <= ost - OST_W'(1);
        default: ost <= ost;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            pixels_q     <= cfg_pixels;
            slices_q     <= cfg_ch_slices;
            in_stride_q  <= cfg_in_surface_stride;
            out_stride_q <= cfg_out_surface_stride;
            in_slice     <= cfg_in_base;
            cls_src      <= cfg_cls_base;
            out_slice    <= cfg_out_base;
            slice        <= '0;
            pix          <= '0;
            if (cfg_ch_slices != '0) begin
              state        <= CLS;
              cmd_pend     <= 1'b1;
              cmd_src_addr <= cfg_cls_base;
              cmd_dst_addr <= cfg_out_base;
              cmd_len      <= LEN_W'(1);
              cmd_last     <= (cfg_ch_slices == CNT_W'(1)) && (cfg_pixels == '0);
            end else begin
              state <= DRAIN;
            end
          end
        end
        CLS: begin
          if (hs) begin
            if (cmd_last) begin
              cmd_pend <= 1'b0;
              state    <= DRAIN;
            end else if (pixels_q != '0) begin
              state        <= FEAT;
              pix          <= '0;
              cmd_src_addr <= in_slice;
              cmd_dst_addr <= out_slice + PB;
              cmd_len      <= burst_len(pixels_q);
              cmd_last     <= last_slice && (pixels_q <= MB);
            end
          end
        end
        FEAT: begin
          if (hs) begin
            if (cmd_last) begin
              cmd_pend <= 1'b0;
              state    <= DRAIN;
            end else if (feat_more) begin
              pix          <= pix_nxt;
              cmd_src_addr <= cmd_src_addr + feat_step;
              cmd_dst_addr <= cmd_dst_addr + feat_step;
              cmd_len      <= burst_len(rem_nxt);
              cmd_last     <= last_slice && (rem_nxt <= MB);
            end
          end
        end
        DRAIN: begin
          // Look ahead at this cycle's completion so done follows it by one cycle.
          if ((ost == '0) || ((ost == OST_W'(1)) && dec)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Slice advance is folded into the handshake: the next CLS command loads directly.
      if (adv_slice) begin
        state        <= CLS;
        slice        <= slice_nxt;
        in_slice     <= in_slice + in_stride_q;
        cls_src      <= cls_src + PB;
        out_slice    <= out_slice + out_stride_q;
        cmd_src_addr <= cls_src + PB;
        cmd_dst_addr <= out_slice + out_stride_q;
        cmd_len      <= LEN_W'(1);
        cmd_last     <= last_slice_nxt && (pixels_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_concat_cmd_scheduler.sv
// Self-checking bench for concat_cmd_scheduler: table of job configurations checked
// against a command scoreboard, plus hand-written outstanding-limit and reset sequences.
module tb_concat_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] cfg_pixels, cfg_ch_slices;
  logic [31:0] cfg_in_base, cfg_in_surface_stride, cfg_cls_base;
  logic [31:0] cfg_out_base, cfg_out_surface_stride;
  logic        busy, done, cmd_valid, cmd_ready, cmd_last, cpl_valid;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [4:0]  cmd_len;

  concat_cmd_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_pixels(cfg_pixels), .cfg_ch_slices(cfg_ch_slices),
    .cfg_in_base(cfg_in_base), .cfg_in_surface_stride(cfg_in_surface_stride),
    .cfg_cls_base(cfg_cls_base), .cfg_out_base(cfg_out_base),
    .cfg_out_surface_stride(cfg_out_surface_stride),
    .busy(busy), .done(done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
    .cmd_len(cmd_len), .cmd_last(cmd_last), .cpl_valid(cpl_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [4:0]  len;
    logic        last;
  } cmd_t;

  typedef struct {
    int          pixels;
    int          slices;
    logic [31:0] in_base;
    logic [31:0] in_stride;
    logic [31:0] cls_base;
    logic [31:0] out_base;
    logic [31:0] out_stride;
    bit          rnd_ready;
    int          cpl_dly;
    bit          poke_start;
    int          exp_cmds;
  } vec_t;

  cmd_t exp_q[$];
  cmd_t obs_q[$];
  vec_t vecs[8];

  int checks = 0, errors = 0;
  int cycle = 0, hs_cnt = 0, done_cnt = 0, last_cnt = 0;
  int last_cpl_cycle = 0, done_cycle = 0;
  bit hs_flag = 0;

  bit          auto_mode = 1;
  bit          rnd_ready = 0;
  int          cpl_dly = 3;
  logic        man_ready = 1'b0, man_cpl = 1'b0;
  logic        auto_ready = 1'b1, auto_cpl = 1'b0;
  logic [15:0] pipe = '0;

  assign cmd_ready = auto_mode ? auto_ready : man_ready;
  assign cpl_valid = auto_mode ? auto_cpl : man_cpl;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference command stream written directly from the address formulas.
  task automatic push_expected(input vec_t v);
    cmd_t c;
    int   len;
    for (int s = 0; s < v.slices; s++) begin
      c.src  = v.cls_base + 32'(s) * 32'd32;
      c.dst  = v.out_base + 32'(s) * v.out_stride;
      c.len  = 5'd1;
      c.last = (s == v.slices - 1) && (v.pixels == 0);
      exp_q.push_back(c);
      for (int p = 0; p < v.pixels; p += len) begin
        len    = (v.pixels - p > 16) ? 16 : v.pixels - p;
        c.src  = v.in_base + 32'(s) * v.in_stride + 32'(p) * 32'd32;
        c.dst  = v.out_base + 32'(s) * v.out_stride + 32'(p + 1) * 32'd32;
        c.len  = 5'(len);
        c.last = (s == v.slices - 1) && (p + len == v.pixels);
        exp_q.push_back(c);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    cmd_t cur, prev, e;
    bit   prev_stall = 0;
    forever begin
      @(negedge clk);
      cycle++;
      hs_flag = 0;
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      if (cpl_valid) last_cpl_cycle = cycle;
      if (done) begin
        done_cnt++;
        done_cycle = cycle;
      end
      cur.src  = cmd_src_addr;
      cur.dst  = cmd_dst_addr;
      cur.len  = cmd_len;
      cur.last = cmd_last;
      if (prev_stall && cmd_valid)
        check("stall_hold", {cur.src, cur.dst, cur.len, cur.last},
              {prev.src, prev.dst, prev.len, prev.last});
      prev_stall = cmd_valid && !cmd_ready;
      prev       = cur;
      if (cmd_valid && cmd_ready) begin
        hs_flag = 1;
        hs_cnt++;
        obs_q.push_back(cur);
        if (cmd_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_cmd", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_src", cur.src, e.src);
          check("cmd_dst", cur.dst, e.dst);
          check("cmd_len", cur.len, e.len);
          check("cmd_last", cur.last, e.last);
        end
      end
    end
  end

  // Mover model: ready pattern and completions a fixed delay after each handshake.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) pipe = '0;
      else     pipe = {pipe[14:0], hs_flag};
      auto_cpl   = (cpl_dly > 0) ? pipe[cpl_dly-1] : 1'b0;
      auto_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic load_cfg(input vec_t v);
    cfg_pixels             = 16'(v.pixels);
    cfg_ch_slices          = 16'(v.slices);
    cfg_in_base            = v.in_base;
    cfg_in_surface_stride  = v.in_stride;
    cfg_cls_base           = v.cls_base;
    cfg_out_base           = v.out_base;
    cfg_out_surface_stride = v.out_stride;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v = vecs[idx];
    bit   got_done = 0;
    exp_q.delete(); obs_q.delete();
    hs_cnt = 0; done_cnt = 0; last_cnt = 0;
    auto_mode = 1; rnd_ready = v.rnd_ready; cpl_dly = v.cpl_dly;
    load_cfg(v);
    push_expected(v);
    pulse_start();
    @(negedge clk);
    check($sformatf("busy_after_start[%0d]", idx), busy, 1);
    if (v.slices > 0) begin
      check($sformatf("first_valid[%0d]", idx), cmd_valid, 1);
    end else begin
      check("zero_slices_done_early", done, 0);
      @(negedge clk);
      check("zero_slices_done_at_2", done, 1);
    end
    if (v.poke_start) begin
      repeat (4) @(posedge clk);
      pulse_start();
    end
    for (int n = 0; n < 20000; n++) begin
      if (done_cnt != 0) begin
        got_done = 1;
        break;
      end
      @(posedge clk);
    end
    check($sformatf("done_seen[%0d]", idx), got_done, 1);
    repeat (4) @(posedge clk);
    #2;
    check($sformatf("cmd_count[%0d]", idx), hs_cnt, v.exp_cmds);
    check($sformatf("queue_empty[%0d]", idx), exp_q.size(), 0);
    check($sformatf("done_once[%0d]", idx), done_cnt, 1);
    check($sformatf("last_count[%0d]", idx), last_cnt, (v.exp_cmds > 0) ? 1 : 0);
    check($sformatf("busy_idle[%0d]", idx), busy, 0);
    if (v.exp_cmds > 0)
      check($sformatf("done_after_cpl[%0d]", idx), done_cycle, last_cpl_cycle + 1);
    if (idx == 0) begin
      if (obs_q.size() < 16) begin
        check("vit_obs_size", obs_q.size(), 84);
      end else begin
        check("vit_s1_cls_src", obs_q[14].src, 32'h0200_0020);
        check("vit_s1_cls_dst", obs_q[14].dst, 32'h0300_18A0);
        check("vit_s1_feat_src", obs_q[15].src, 32'h0000_1880);
        check("vit_s1_feat_dst", obs_q[15].dst, 32'h0300_18C0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_src"}, cmd_src_addr, 0);
    check({tag, "_dst"}, cmd_dst_addr, 0);
    check({tag, "_len"}, cmd_len, 0);
    check({tag, "_last"}, cmd_last, 0);
  endtask

  initial begin
    vec_t lim;
    rst = 1'b1; start = 1'b0;
    vecs[0] = '{196, 6, 32'h0, 32'h1880, 32'h0200_0000, 32'h0300_0000, 32'h18A0, 0, 3, 0, 84};
    vecs[1] = '{196, 6, 32'h0, 32'h1880, 32'h0200_0000, 32'h0300_0000, 32'h18A0, 1, 3, 0, 84};
    vecs[2] = '{0, 2, 32'h1000, 32'h40, 32'h0050_0000, 32'h0060_0000, 32'h100, 0, 3, 0, 2};
    vecs[3] = '{16, 1, 32'h10000, 32'h200, 32'h20000, 32'h30000, 32'h220, 0, 2, 0, 2};
    vecs[4] = '{17, 3, 32'h40000, 32'h400, 32'h50000, 32'h60000, 32'h440, 1, 1, 1, 9};
    vecs[5] = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 3, 0, 0};
    vecs[6] = '{5, 2, 32'hFFFF_FFF0, 32'h100, 32'hFFFF_FFE0, 32'hFFFF_FF00, 32'hC0, 0, 9, 0, 4};
    vecs[7] = '{33, 2, 32'h8000, 32'h440, 32'h9000, 32'hA000, 32'h460, 1, 12, 0, 8};
    load_cfg(vecs[0]);

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Spurious completions in IDLE, then the outstanding cap with completions withheld.
    auto_mode = 0; man_ready = 1'b1;
    @(posedge clk); #1 man_cpl = 1'b1;
    @(posedge clk); @(posedge clk); #1 man_cpl = 1'b0;
    lim = '{196, 1, 32'h0, 32'h1880, 32'h0200_0000, 32'h0300_0000, 32'h18A0, 0, 0, 0, 14};
    exp_q.delete(); hs_cnt = 0;
    load_cfg(lim);
    push_expected(lim);
    pulse_start();
    repeat (8) @(posedge clk);
    #2;
    check("limit_hs4", hs_cnt, 4);
    check("limit_valid_low", cmd_valid, 0);
    @(posedge clk); #1 man_cpl = 1'b1;
    @(negedge clk);
    check("limit_release_valid", cmd_valid, 1);
    @(posedge clk); #1 man_cpl = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("limit_hs5", hs_cnt, 5);
    check("limit_held_at_max", cmd_valid, 0);
    check("limit_busy", busy, 1);

    // Abort mid-job with reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #2;
    check_reset_outputs("abort");
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    auto_mode = 1;

    for (int i = 0; i < 8; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/concat_cmd_scheduler.md
# concat_cmd_scheduler

Command scheduler for the class-token CONCAT layer. It splits one CONCAT job into a sequence of copy commands for the shared DDR copy mover, and it limits how many commands are in flight at once. For each channel slice it first prepends the class-token pixel at output pixel 0. It then copies the feature-map pixels to output pixels 1..N in bursts. It sits between the CSR block, which supplies the configuration and `start`, and the AXI copy mover, which returns one completion per command.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `PIXEL_BYTES`, 32: bytes per pixel word (`Tout*MAX_DAT_DW/8`).
- `MAX_BURST`, 16: maximum beats per command.
- `MAX_OUTSTANDING`, 4: maximum number of commands issued but not yet completed.
- `CNT_W`, 16: width of the pixel and slice counters.

Ports (clock and reset first):
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle job launch; sampled only in IDLE.
- `cfg_pixels` in CNT_W: Win*Hin, the input pixels per slice.
- `cfg_ch_slices` in CNT_W: ceil(CH/Tout), the number of channel slices.
- `cfg_in_base`, `cfg_in_surface_stride` in ADDR_W: input feature map base address and per-slice stride.
- `cfg_cls_base` in ADDR_W: class-token base address (one pixel word per slice, contiguous).
- `cfg_out_base`, `cfg_out_surface_stride` in ADDR_W: output base address and per-slice stride.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle `done` is asserted.
- `done` out 1: one-cycle pulse at job end.
- `cmd_valid` out 1, `cmd_ready` in 1: command handshake.
- `cmd_src_addr`, `cmd_dst_addr` out ADDR_W: command source and destination byte addresses.
- `cmd_len` out clog2(MAX_BURST)+1: number of beats, in 1..MAX_BURST.
- `cmd_last` out 1: marks the final command of the job.
- `cpl_valid` in 1: one-cycle pulse, one per completed command.

## Operation
- Configuration is latched into internal registers when `start` is accepted. CSR changes during a job have no effect.
- States and transitions:
  - IDLE: on `start`, go to CLS if `cfg_ch_slices`≠0; otherwise go to DONE.
  - CLS: issue one command:
    - src = cls_base + s*PIXEL_BYTES
    - dst = out_base + s*out_stride
    - len = 1
    - after the handshake, go to FEAT if pixels≠0; otherwise go to NEXT.
  - FEAT: p counts the pixels already copied in this slice. Issue:
    - src = in_base + s*in_stride + p*PIXEL_BYTES
    - dst = out_base + s*out_stride + (p+1)*PIXEL_BYTES
    - len = min(MAX_BURST, pixels−p)
    - after each handshake, p += len; when p == pixels, go to NEXT.
  - NEXT: s += 1; go to CLS if s < slices; otherwise go to DRAIN.
  - DRAIN: wait until the outstanding count is 0, then go to DONE.
  - DONE: assert `done`; go to IDLE.
- Outstanding counter:
  - +1 on each command handshake; −1 on each `cpl_valid`.
  - A handshake and a `cpl_valid` in the same cycle leave it unchanged.
  - `cpl_valid` while the count is 0 is ignored; the counter does not wrap.
- `cmd_valid` is low while outstanding == MAX_OUTSTANDING, unless a `cpl_valid` arrives in the same cycle.
- `cmd_last` is 1 on the final command, which is either the last FEAT command of the last slice or the CLS command of the last slice when pixels = 0.
- Addresses are computed with ADDR_W-bit modular arithmetic. Bursts are not split at 4 KB boundaries; that is the mover's responsibility.
- `start` is ignored while busy.

## Timing
- Reset values: `busy`=0, `done`=0, `cmd_valid`=0, `cmd_src_addr`=0, `cmd_dst_addr`=0, `cmd_len`=0, `cmd_last`=0. The FSM resets to IDLE and all counters to 0.
- Asserting `rst` mid-job aborts the job in the next cycle. No `done` is produced, and completions already in flight are not tracked.
- All command outputs are registered. The first `cmd_valid` rises 1 cycle after `start`.
- The command fields hold steady while `cmd_valid` is high and `cmd_ready` is low.
- When the mover and completions allow, the scheduler issues one command per cycle with no bubble between commands, including across CLS/FEAT and slice boundaries. The NEXT step is folded into the handshake cycle and costs no extra cycle.
- `done` rises 1 cycle after the cycle in which the last outstanding completion arrives and all commands have been issued. `busy` falls in the same cycle that `done` rises.
- With slices = 0, `done` pulses 2 cycles after `start` and no commands are issued.

## Test plan
- Full ViT layer: pixels=196, slices=6, MAX_BURST=16, in_stride=0x1880, out_stride=0x18A0, out_base=0x3000000, cls_base=0x2000000, `cmd_ready` held at 1, completions returned 3 cycles after each command.
  - Expect 84 commands: 14 per slice, with lengths 1, then 16 ×12, then 4.
  - Slice-1 CLS command: src=0x2000020, dst=0x30018A0.
  - First FEAT command of slice 1: src=0x1880, dst=0x30018C0.
  - `cmd_last` set only on command 84; `done` pulses exactly once.
- Backpressure: `cmd_ready` toggled randomly.
  - The command fields must not change while stalled.
  - The command stream must be identical to the unstalled run.
- Outstanding limit: `cpl_valid` withheld.
  - `cmd_valid` drops after exactly 4 handshakes.
  - A single `cpl_valid` releases exactly one more command.
  - A same-cycle `cpl_valid` plus handshake with the count at 4 issues the command and keeps the count at 4.
- Degenerate configurations:
  - pixels=0, slices=2: exactly two len-1 CLS commands; the second has `cmd_last`=1.
  - slices=0: no commands; `done` 2 cycles after `start`.
- Protocol edge cases:
  - `start` pulsed mid-job: ignored.
  - Spurious `cpl_valid` in IDLE: the count stays at 0.
  - Mid-job `rst`: all outputs return to their reset values the next cycle, and a new job then runs correctly.
